// File: rtl/lut_neuron_pipe_pkg.sv
// Shared types and helpers for the reprogrammable truth-table neuron.
package lut_neuron_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_DRAIN,
    ST_LOAD,
    ST_RUN
  } state_e;

  function automatic int unsigned addr_w(input int unsigned fan_in, input int unsigned in_bits);
    return fan_in * in_bits;
  endfunction

endpackage

// File: rtl/lut_neuron_pipe_if.sv
// Config stream plus valid/ready inference streams of the truth-table neuron.
interface lut_neuron_pipe_if
  import lut_neuron_pkg::*;
#(
  parameter int unsigned IN_BITS  = 2,
  parameter int unsigned FAN_IN   = 3,
  parameter int unsigned OUT_BITS = 2
);
  localparam int unsigned ADDR_W = addr_w(FAN_IN, IN_BITS);

  logic                cfg_start;
  logic                cfg_wvalid;
  logic [OUT_BITS-1:0] cfg_wdata;
  logic                cfg_done;
  logic                tbl_loaded;
  logic                in_valid;
  logic                in_ready;
  logic [ADDR_W-1:0]   in_data;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_BITS-1:0] out_data;

  modport master (
    output cfg_start, cfg_wvalid, cfg_wdata, in_valid, in_data, out_ready,
    input  cfg_done, tbl_loaded, in_ready, out_valid, out_data
  );

  modport slave (
    input  cfg_start, cfg_wvalid, cfg_wdata, in_valid, in_data, out_ready,
    output cfg_done, tbl_loaded, in_ready, out_valid, out_data
  );

endinterface

// File: rtl/lut_neuron_pipe_table.sv
// Single-write-port, asynchronous-read truth table storage (not reset).
module lut_neuron_table #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [OUT_BITS-1:0] wdata,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [OUT_BITS-1:0] rdata
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  (* ram_style = "distributed" *)
  logic [OUT_BITS-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/lut_neuron_pipe.sv
// Reprogrammable truth-table neuron: load FSM, table and 2-stage valid/ready pipeline.
module lut_neuron_pipe
  import lut_neuron_pkg::*;
#(
  parameter int unsigned IN_BITS  = 2,
  parameter int unsigned FAN_IN   = 3,
  parameter int unsigned OUT_BITS = 2
) (
  input logic               clk,
  input logic               rst_n,
  lut_neuron_pipe_if.slave  bus
);
  localparam int unsigned ADDR_W = addr_w(FAN_IN, IN_BITS);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cfg_done_q, cfg_done_d;
  logic                s1_valid_q;
  logic [ADDR_W-1:0]   s1_addr_q;
  logic                out_valid_q;
  logic [OUT_BITS-1:0] out_data_q;
  logic                tbl_we;
  logic [OUT_BITS-1:0] tbl_rdata;
  logic                adv;
  logic                in_ready;

  assign adv      = !out_valid_q || bus.out_ready;
  assign in_ready = (state_q == ST_RUN) && adv;

  lut_neuron_table #(
    .ADDR_W   (ADDR_W),
    .OUT_BITS (OUT_BITS)
  ) u_table (
    .clk   (clk),
    .we    (tbl_we),
    .waddr (addr_q),
    .wdata (bus.cfg_wdata),
    .raddr (s1_addr_q),
    .rdata (tbl_rdata)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cfg_done_d = 1'b0;
    tbl_we     = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (bus.cfg_start) begin
          state_d = ST_LOAD;
          addr_d  = '0;
        end
      end
      ST_RUN: begin
        if (bus.cfg_start) begin
          state_d = (s1_valid_q || out_valid_q) ? ST_DRAIN : ST_LOAD;
          addr_d  = '0;
        end
      end
      ST_DRAIN: begin
        if (!s1_valid_q && !out_valid_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // A restart takes priority over a same-cycle write, whose data is dropped.
        if (bus.cfg_start) begin
          addr_d = '0;
        end else if (bus.cfg_wvalid) begin
          tbl_we = 1'b1;
          addr_d = addr_q + 1'b1;
          if (addr_q == '1) begin
            state_d    = ST_RUN;
            cfg_done_d = 1'b1;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      addr_q     <= '0;
      cfg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cfg_done_q <= cfg_done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (adv) begin
      s1_valid_q  <= bus.in_valid && in_ready;
      s1_addr_q   <= bus.in_data;
      out_valid_q <= s1_valid_q;
      out_data_q  <= tbl_rdata;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.tbl_loaded = (state_q == ST_RUN);
  assign bus.cfg_done   = cfg_done_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;

endmodule
